// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx_arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_CLKS_PER_BIT = 87;

  // Watchdog counter width able to hold values up to clks.
  function automatic int unsigned timeout_w(input int unsigned clks);
    return $clog2(clks + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter bus of uart_tx_arbiter.
// master = arbiter side; slave = byte producers plus the uart_tx2 instance.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_byte;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   grant;
  logic               tx_dv;
  logic [7:0]         tx_byte;
  logic               tx_done;
  logic               busy;
  logic               err;

  modport master (
    input  req_valid, req_byte, req_last, tx_done,
    output req_ready, grant, tx_dv, tx_byte, busy, err
  );

  modport slave (
    output req_valid, req_byte, req_last, tx_done,
    input  req_ready, grant, tx_dv, tx_byte, busy, err
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr_i with wrap,
// or only lock_idx_i when lock_en_i is set.
module uart_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             lock_en_i,
  input  logic [PTR_W-1:0] lock_idx_i,
  output logic [PTR_W-1:0] win_c_o,
  output logic             valid_c_o
);

  logic [PTR_W-1:0] cand_c;

  always_comb begin
    win_c_o   = '0;
    valid_c_o = 1'b0;
    cand_c    = '0;
    if (lock_en_i) begin
      win_c_o   = lock_idx_i;
      valid_c_o = req_i[lock_idx_i];
    end else begin
      // Modulo keeps the wrap correct for non-power-of-2 N_REQ.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        cand_c = PTR_W'((32'(ptr_i) + i) % N_REQ);
        if (!valid_c_o && req_i[cand_c]) begin
          win_c_o   = cand_c;
          valid_c_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx2 between N_REQ byte producers, with a DONE watchdog.
// Optional frame lock enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned TIMEOUT_CLKS = 12 * CLKS_PER_BIT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = timeout_w(TIMEOUT_CLKS);
  // Watchdog value whose increment reaches TIMEOUT_CLKS-1.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CLKS - 2);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(N_REQ - 1);

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] win_q, win_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             tx_dv_q, tx_dv_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [PTR_W-1:0] pick_win_c;
  logic             pick_valid_c;
  logic [7:0]       byte_sel_c;
  logic [PTR_W-1:0] next_ptr_c;
  logic [N_REQ-1:0] onehot_c;
  logic             lock_en_c;

`ifdef UART_ARB_LOCK_EN
  // The locked requester is always the last winner, so win_q doubles as the lock index.
  logic lock_q, lock_d;
  assign lock_en_c = lock_q;
`else
  logic unused_last_c;
  assign lock_en_c     = 1'b0;
  assign unused_last_c = ^bus.req_last;
`endif

  uart_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i      (bus.req_valid),
    .ptr_i      (ptr_q),
    .lock_en_i  (lock_en_c),
    .lock_idx_i (win_q),
    .win_c_o    (pick_win_c),
    .valid_c_o  (pick_valid_c)
  );

  // Byte lane of the current pick.
  always_comb begin
    byte_sel_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_win_c == PTR_W'(k)) byte_sel_c = bus.req_byte[8*k +: 8];
    end
  end

  assign onehot_c   = N_REQ'(1) << pick_win_c;
  assign next_ptr_c = (win_q == PTR_MAX) ? '0 : win_q + PTR_W'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      wdog_q      <= '0;
      grant_q     <= '0;
      req_ready_q <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= 8'h00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      wdog_q      <= wdog_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      tx_dv_q     <= tx_dv_d;
      tx_byte_q   <= tx_byte_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef UART_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  // Next state; pulse outputs are set on the transition into the cycle where they must be high.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    wdog_d      = wdog_q;
    grant_d     = grant_q;
    tx_byte_d   = tx_byte_q;
    req_ready_d = '0;
    tx_dv_d     = 1'b0;
    busy_d      = 1'b0;
    err_d       = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid_c) begin
          state_d     = LAUNCH;
          win_d       = pick_win_c;
          grant_d     = onehot_c;
          tx_byte_d   = byte_sel_c;
          tx_dv_d     = 1'b1;
          req_ready_d = onehot_c;
          busy_d      = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        wdog_d  = '0;
        busy_d  = 1'b1;
`ifdef UART_ARB_LOCK_EN
        lock_d  = ~bus.req_last[win_q];
`endif
      end
      WAIT_DONE: begin
        busy_d = 1'b1;
        wdog_d = wdog_q + WD_W'(1);
        if (bus.tx_done) begin
          state_d = IDLE;
          ptr_d   = next_ptr_c;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (wdog_q == WD_LAST) begin
          state_d = IDLE;
          ptr_d   = next_ptr_c;
          grant_d = '0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
`ifdef UART_ARB_LOCK_EN
          lock_d  = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.grant     = grant_q;
  assign bus.tx_dv     = tx_dv_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx2 DONE model and byte producers.
// The frame-lock scenario is compiled only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned TIMEOUT   = 1044;
  localparam int          DONE_DLY  = 5;

  logic clk;
  logic rst;

  uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  uart_tx_arbiter #(
    .N_REQ        (N_REQ),
    .CLKS_PER_BIT (87),
    .TIMEOUT_CLKS (TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int         n_chk;
  int         n_err;
  int         cyc;
  int         rem [N_REQ];
  logic [7:0] cur [N_REQ];
  logic [3:0] pend;
  int         dcnt;
  logic       done_en;
  logic [7:0] l_byte [$];
  int         l_cyc  [$];
  logic [3:0] l_rdy  [$];
  logic [3:0] l_gnt  [$];
  int         d_cyc  [$];
  int         err_cyc;
  int         t0;
  logic       acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N_REQ; k++) begin
      bus.req_valid[k]       = (rem[k] != 0);
      bus.req_byte[8*k +: 8] = cur[k];
      bus.req_last[k]        = (rem[k] == 1);
    end
  endtask

  task automatic load(input int k, input int n, input logic [7:0] b);
    rem[k] = n;
    cur[k] = b;
    drive();
  endtask

  // One clock: transmitter model, producers, and launch/done/err logging, all #1 after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.tx_done = 1'b0;
    if (dcnt != 0) begin
      dcnt--;
      if (dcnt == 0 && done_en) bus.tx_done = 1'b1;
    end
    if (bus.tx_dv) dcnt = DONE_DLY;
    for (int k = 0; k < N_REQ; k++) begin
      if (pend[k] && rem[k] != 0) rem[k]--;
    end
    pend = bus.req_ready;
    drive();
    if (bus.tx_dv) begin
      l_byte.push_back(bus.tx_byte);
      l_cyc.push_back(cyc);
      l_rdy.push_back(bus.req_ready);
      l_gnt.push_back(bus.grant);
    end
    if (bus.tx_done) d_cyc.push_back(cyc);
    if (bus.err) err_cyc = cyc;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < N_REQ; k++) begin
      rem[k] = 0;
      cur[k] = 8'h00;
    end
    pend    = '0;
    dcnt    = 0;
    done_en = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    l_byte.delete();
    l_cyc.delete();
    l_rdy.delete();
    l_gnt.delete();
    d_cyc.delete();
    err_cyc = -1;
  endtask

  task automatic wait_launch(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && l_byte.size() < n; i++) tick();
    chk(tag, 32'(l_byte.size()), 32'(n));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!bus.tx_done && i < budget) begin
      tick();
      i++;
    end
    chk(tag, 32'(bus.tx_done), 32'd1);
  endtask

  function automatic logic [7:0] lb(input int i);
    return (l_byte.size() > i) ? l_byte[i] : 8'hxx;
  endfunction

  function automatic int lc(input int i);
    return (l_cyc.size() > i) ? l_cyc[i] : -1000;
  endfunction

  function automatic int dc(input int i);
    return (d_cyc.size() > i) ? d_cyc[i] : -1000;
  endfunction

  initial begin
    n_chk        = 0;
    n_err        = 0;
    cyc          = 0;
    bus.tx_done  = 1'b0;
    bus.req_valid = '0;
    bus.req_byte  = '0;
    bus.req_last  = '0;

    // Reset state and quiet idle
    do_reset();
    chk("rst_outs", 32'({bus.req_ready, bus.grant, bus.tx_dv, bus.busy, bus.err}), 32'd0);
    chk("rst_byte", 32'(bus.tx_byte), 32'h00);
    acc = 1'b0;
    repeat (100) begin
      tick();
      acc = acc | (|{bus.req_ready, bus.grant, bus.tx_dv, bus.busy, bus.err, bus.tx_byte});
    end
    chk("idle_quiet", 32'(acc), 32'd0);

    // Single requester 2
    do_reset();
    load(2, 1, 8'hA5);
    t0 = cyc;
    wait_launch("single_n", 1, 10);
    chk("single_lat", 32'(lc(0) - t0), 32'd1);
    chk("single_byte", 32'(lb(0)), 32'hA5);
    chk("single_rdy", 32'((l_rdy.size() > 0) ? l_rdy[0] : 4'hx), 32'b0100);
    chk("single_gnt", 32'((l_gnt.size() > 0) ? l_gnt[0] : 4'hx), 32'b0100);
    tick();
    chk("single_dv_pulse", 32'({bus.tx_dv, bus.req_ready}), 32'd0);
    chk("single_busy", 32'(bus.busy), 32'd1);
    wait_done("single_done", 20);
    chk("single_gnt_hold", 32'(bus.grant), 32'b0100);
    tick();
    chk("single_gnt_clr", 32'({bus.grant, bus.busy}), 32'd0);
    chk("single_byte_hold", 32'(bus.tx_byte), 32'hA5);

    // All four valid: order 0,1,2,3,0, two cycles after each DONE
    do_reset();
    load(0, 2, 8'h10);
    load(1, 1, 8'h11);
    load(2, 1, 8'h12);
    load(3, 1, 8'h13);
    wait_launch("rr_n", 5, 200);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("rr_byte%0d", i), 32'(lb(i)), 32'h10 + 32'(i % 4));
    end
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("rr_gap%0d", i), 32'(lc(i) - dc(i-1)), 32'd2);
    end

    // Watchdog: DONE never comes for requester 1, then requester 2 is served
    do_reset();
    done_en = 1'b0;
    load(1, 1, 8'h21);
    load(2, 1, 8'h22);
    wait_launch("wd_n", 1, 10);
    chk("wd_first", 32'(lb(0)), 32'h21);
    for (int i = 0; i < 1100 && err_cyc < 0; i++) tick();
    chk("wd_err_time", 32'(err_cyc - lc(0)), 32'd1044);
    chk("wd_idle", 32'({bus.grant, bus.busy}), 32'd0);
    done_en = 1'b1;
    tick();
    chk("wd_err_pulse", 32'(bus.err), 32'd0);
    chk("wd_next_dv", 32'(bus.tx_dv), 32'd1);
    chk("wd_next_byte", 32'(bus.tx_byte), 32'h22);
    wait_done("wd_next_done", 20);

    // Reset in WAIT_DONE, stray DONE afterwards, pointer back to 0
    do_reset();
    load(1, 1, 8'h51);
    wait_launch("mid_n1", 1, 10);
    wait_done("mid_done1", 20);
    load(2, 1, 8'h52);
    wait_launch("mid_n2", 2, 10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_outs", 32'({bus.req_ready, bus.grant, bus.tx_dv, bus.busy}), 32'd0);
    acc = 1'b0;
    repeat (8) begin
      tick();
      acc = acc | bus.tx_dv | bus.busy;
    end
    chk("mid_no_dv", 32'(acc), 32'd0);
    chk("mid_stray_seen", 32'(d_cyc.size()), 32'd2);
    load(0, 1, 8'h50);
    load(3, 1, 8'h53);
    wait_launch("mid_n3", 4, 40);
    chk("mid_first", 32'(lb(2)), 32'h50);
    chk("mid_second", 32'(lb(3)), 32'h53);

`ifdef UART_ARB_LOCK_EN
    // Frame lock: requester 1 sends three bytes before requester 0
    do_reset();
    load(1, 3, 8'h31);
    wait_launch("lock_n1", 1, 10);
    load(0, 1, 8'h30);
    wait_launch("lock_n", 4, 100);
    chk("lock_b0", 32'(lb(0)), 32'h31);
    chk("lock_b1", 32'(lb(1)), 32'h31);
    chk("lock_b2", 32'(lb(2)), 32'h31);
    chk("lock_b3", 32'(lb(3)), 32'h30);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
